// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  // Widths of the buffered beat record; the fetch parameters must fit inside them.
  localparam int FETCH_MAX_DATA_WIDTH = 64;
  localparam int FETCH_MAX_ADDR_WIDTH = 64;
  localparam int FETCH_SLOT_WIDTH     = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_MAX_DATA_WIDTH-1:0] data;
    logic [FETCH_MAX_ADDR_WIDTH-1:0] addr;
    logic [FETCH_SLOT_WIDTH-1:0]     start_slot;
  } fetch_beat_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] ARCACHE_DEF = 4'b0011;
  localparam logic [2:0] ARPROT_INSN = 3'b100;

  function automatic int slots_per_beat(input int data_width, input int insn_width);
    return data_width / insn_width;
  endfunction

  function automatic int burst_bytes(input int beats, input int data_width);
    return beats * data_width / 8;
  endfunction

endpackage

// File: rtl/fetch_beat_fifo.sv
// Prefetch FIFO of fetch beats; head is visible combinationally so the
// output stage can slice instructions out of it without an extra cycle.
module fetch_beat_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_beat_t              push_beat,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_beat_t              head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_beat_t mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] used;

  // The extra pointer bit tells full from empty.
  assign used       = wr_ptr_reg - rd_ptr_reg;
  assign empty      = (used == '0);
  assign free_count = (AW + 1)'(DEPTH) - used;
  assign head       = mem[rd_ptr_reg[AW-1:0]];

  // Beat storage; a flush discards the write of that cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_beat;
    end
  end

  // Pointer update: push and pop in the same cycle are both honoured.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_fetch_prefetch.sv
// Instruction-fetch front end: issues aligned AXI4 INCR bursts, buffers beats,
// and hands out one instruction per cycle with its PC.
module axi_fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 13,
  parameter int INSN_WIDTH  = 32,
  parameter int BURST_BEATS = 8,
  parameter int FIFO_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_WIDTH-1:0] insn_data,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  fetch_error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int SLOTS      = slots_per_beat(DATA_WIDTH, INSN_WIDTH);
  localparam int BBYTES     = burst_bytes(BURST_BEATS, DATA_WIDTH);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int INSN_BYTES = INSN_WIDTH / 8;
  localparam int INSN_OFF   = $clog2(INSN_BYTES);
  localparam int FREE_W     = $clog2(FIFO_BEATS) + 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_MASK = ~(ADDR_WIDTH'(BBYTES - 1));
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ~(ADDR_WIDTH'(DATA_BYTES - 1));
  localparam logic [FETCH_SLOT_WIDTH-1:0] SLOT_LAST = FETCH_SLOT_WIDTH'(SLOTS - 1);

  function automatic logic [FETCH_SLOT_WIDTH-1:0] pc_slot(input logic [ADDR_WIDTH-1:0] pc);
    return FETCH_SLOT_WIDTH'((pc >> INSN_OFF) & ADDR_WIDTH'(SLOTS - 1));
  endfunction

  fetch_state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]         fetch_pc_reg, fetch_pc_next;
  logic                          fetch_error_reg, fetch_error_next;
  logic [ADDR_WIDTH-1:0]         ar_addr_reg, ar_addr_next;
  logic [ADDR_WIDTH-1:0]         ar_beat_reg, ar_beat_next;
  logic [FETCH_SLOT_WIDTH-1:0]   ar_slot_reg, ar_slot_next;
  logic                          drain_pend_reg, drain_pend_next;
  logic [ADDR_WIDTH-1:0]         beat_addr_reg, beat_addr_next;
  logic [FETCH_SLOT_WIDTH-1:0]   slot_reg;
  logic                          slot_live_reg;

  logic                          fifo_push;
  fetch_beat_t                   push_beat;
  logic                          fifo_pop;
  fetch_beat_t                   head;
  logic                          fifo_empty;
  logic [FREE_W-1:0]             free_count;
  logic [FREE_W-1:0]             free_eff;
  logic [ADDR_WIDTH-1:0]         pc_eff;
  logic                          err_eff;
  logic                          r_hs;
  logic [FETCH_SLOT_WIDTH-1:0]   cur_slot;
  logic                          insn_fire;
  logic [DATA_WIDTH-1:0]         head_shifted;
  logic                          unused_rid;

  // IDs are constant zero on this port, so the returned ID carries no information.
  assign unused_rid = ^m_axi_rid;

  fetch_beat_fifo #(
    .DEPTH (FIFO_BEATS)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_beat  (push_beat),
    .pop        (fifo_pop),
    .flush      (redirect_valid),
    .head       (head),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  assign r_hs     = m_axi_rvalid && m_axi_rready;
  // A redirect takes effect in the same cycle, so decisions see the post-redirect view.
  assign pc_eff   = redirect_valid ? redirect_pc : fetch_pc_reg;
  assign err_eff  = redirect_valid ? 1'b0 : fetch_error_reg;
  assign free_eff = redirect_valid ? FREE_W'(FIFO_BEATS) : free_count;

  // Fetch state register and per-burst bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      fetch_pc_reg    <= entry;
      fetch_error_reg <= 1'b0;
      ar_addr_reg     <= '0;
      ar_beat_reg     <= '0;
      ar_slot_reg     <= '0;
      drain_pend_reg  <= 1'b0;
      beat_addr_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      fetch_error_reg <= fetch_error_next;
      ar_addr_reg     <= ar_addr_next;
      ar_beat_reg     <= ar_beat_next;
      ar_slot_reg     <= ar_slot_next;
      drain_pend_reg  <= drain_pend_next;
      beat_addr_reg   <= beat_addr_next;
    end
  end

  // Next-state, FIFO push and redirect/error handling.
  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    fetch_error_next = fetch_error_reg;
    ar_addr_next     = ar_addr_reg;
    ar_beat_next     = ar_beat_reg;
    ar_slot_next     = ar_slot_reg;
    drain_pend_next  = drain_pend_reg;
    beat_addr_next   = beat_addr_reg;
    fifo_push        = 1'b0;
    push_beat        = '0;
    push_beat.data[DATA_WIDTH-1:0] = m_axi_rdata;
    push_beat.addr[ADDR_WIDTH-1:0] = beat_addr_reg;
    // Only the beat holding the fetch PC starts mid-beat; earlier slots are skipped.
    push_beat.start_slot = (beat_addr_reg == ar_beat_reg) ? ar_slot_reg : '0;

    case (state_reg)
      IDLE: begin
        // Space for a whole burst is reserved up front so rready never stalls.
        if (free_eff >= FREE_W'(BURST_BEATS) && !err_eff) begin
          state_next   = REQ;
          ar_addr_next = pc_eff & BURST_MASK;
          ar_beat_next = pc_eff & BEAT_MASK;
          ar_slot_next = pc_slot(pc_eff);
        end
      end
      REQ: begin
        drain_pend_next = drain_pend_reg || redirect_valid;
        if (m_axi_arready) begin
          beat_addr_next  = ar_addr_reg;
          drain_pend_next = 1'b0;
          if (drain_pend_reg || redirect_valid) begin
            state_next = DRAIN;
          end else begin
            state_next    = BURST;
            fetch_pc_next = ar_addr_reg + ADDR_WIDTH'(BBYTES);
          end
        end
      end
      BURST: begin
        if (redirect_valid) begin
          state_next = (r_hs && m_axi_rlast) ? IDLE : DRAIN;
        end else if (r_hs) begin
          beat_addr_next = beat_addr_reg + ADDR_WIDTH'(DATA_BYTES);
          if (m_axi_rresp != RESP_OKAY) begin
            fetch_error_next = 1'b1;
          end else if (!fetch_error_reg && beat_addr_reg >= ar_beat_reg) begin
            fifo_push = 1'b1;
          end
          if (m_axi_rlast) begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (r_hs && m_axi_rlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_next    = redirect_pc;
      fetch_error_next = 1'b0;
    end
  end

  // Output slot tracking: a fresh head starts at its recorded start slot.
  assign cur_slot  = slot_live_reg ? slot_reg : head.start_slot;
  assign insn_fire = !fifo_empty && insn_ready && !redirect_valid;
  assign fifo_pop  = insn_fire && (cur_slot == SLOT_LAST);

  // Slot pointer advances per handshake and resets whenever the head beat changes.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      slot_reg      <= '0;
      slot_live_reg <= 1'b0;
    end else if (insn_fire) begin
      if (fifo_pop) begin
        slot_reg      <= '0;
        slot_live_reg <= 1'b0;
      end else begin
        slot_reg      <= cur_slot + 1'b1;
        slot_live_reg <= 1'b1;
      end
    end
  end

  assign head_shifted = head.data[DATA_WIDTH-1:0] >> (cur_slot * INSN_WIDTH);
  assign insn_valid   = !fifo_empty;
  assign insn_data    = head_shifted[INSN_WIDTH-1:0];
  assign insn_pc      = head.addr[ADDR_WIDTH-1:0] + (ADDR_WIDTH'(cur_slot) << INSN_OFF);
  assign fetch_error  = fetch_error_reg;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = ar_addr_reg;
  assign m_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_BYTES));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = ARCACHE_DEF;
  assign m_axi_arprot  = ARPROT_INSN;
  assign m_axi_arvalid = (state_reg == REQ);
  assign m_axi_rready  = (state_reg == BURST) || (state_reg == DRAIN);

endmodule

// File: tb/tb_axi_fetch_prefetch.sv
// Directed bench for axi_fetch_prefetch with a small AXI read slave model.
module tb_axi_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [63:0] insn_pc;
  logic        fetch_error;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_fetch_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .fetch_error    (fetch_error),
    .m_axi_arid     (m_axi_arid),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arlock   (m_axi_arlock),
    .m_axi_arcache  (m_axi_arcache),
    .m_axi_arprot   (m_axi_arprot),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rid      (m_axi_rid),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory image: each 32-bit word is its address xor a marker.
  function automatic logic [31:0] insn_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Slave model controls and logs
  bit          slave_en = 1'b0;
  bit          slave_busy = 1'b0;
  int          ar_delay = 0;
  int          err_beat = -1;
  int          slave_beat = -1;
  int          slave_timeout = 0;
  int          ar_unstable = 0;
  logic [63:0] slave_burst_addr = '0;
  logic [63:0] ar_log[$];
  logic [7:0]  seen_arlen;
  logic [2:0]  seen_arsize;
  logic [1:0]  seen_arburst;
  logic [3:0]  seen_arcache;
  logic [2:0]  seen_arprot;
  logic [12:0] seen_arid;
  logic        seen_arlock;

  // AXI read slave: one burst at a time, optional AR stall and error beat.
  initial begin
    logic [63:0] a;
    int dly;
    int w;
    bit hs;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rid     = '0;
    forever begin
      @(posedge clk); #1;
      if (slave_en && !reset && m_axi_arvalid) begin
        slave_busy = 1'b1;
        a   = m_axi_araddr;
        dly = ar_delay;
        for (int d = 0; d < dly; d++) begin
          @(posedge clk); #1;
          if (m_axi_araddr !== a || m_axi_arvalid !== 1'b1) ar_unstable++;
        end
        m_axi_arready = 1'b1;
        ar_log.push_back(a);
        seen_arlen = m_axi_arlen; seen_arsize = m_axi_arsize; seen_arburst = m_axi_arburst;
        seen_arcache = m_axi_arcache; seen_arprot = m_axi_arprot; seen_arid = m_axi_arid;
        seen_arlock = m_axi_arlock;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        slave_burst_addr = a;
        for (int b = 0; b < 8; b++) begin
          slave_beat   = b;
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = {insn_of(a + 64'(8 * b) + 64'd4), insn_of(a + 64'(8 * b))};
          m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (b == 7);
          hs = 1'b0;
          w  = 0;
          while (!hs) begin
            @(negedge clk);
            hs = m_axi_rready;
            @(posedge clk); #1;
            w++;
            if (!hs && w > 50) begin
              slave_timeout++;
              hs = 1'b1;
            end
          end
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        slave_beat   = -1;
        slave_busy   = 1'b0;
      end
    end
  end

  // Consumer monitor: one line per delivered instruction.
  logic [63:0] got_pc[$];
  logic [31:0] got_data[$];
  always @(negedge clk) begin
    if (!reset && insn_valid && insn_ready && !redirect_valid) begin
      got_pc.push_back(insn_pc);
      got_data.push_back(insn_data);
      $display("[TB] insn pc=%h data=%h", insn_pc, insn_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [63:0] e);
    slave_en = 1'b0;
    for (int i = 0; i < 200 && slave_busy; i++) @(posedge clk);
    #2;
    reset = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    tick(3);
    check_eq("rst_arvalid", m_axi_arvalid, 0);
    check_eq("rst_rready", m_axi_rready, 0);
    check_eq("rst_insn_valid", insn_valid, 0);
    check_eq("rst_fetch_error", fetch_error, 0);
    got_pc.delete();
    got_data.delete();
    ar_log.delete();
    ar_unstable = 0;
    reset = 1'b0;
    slave_en = 1'b1;
  endtask

  task automatic wait_insns(input int n, input string tag);
    int c;
    c = 0;
    while (got_pc.size() < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    #2;
    if (got_pc.size() < n) check_eq(tag, 64'(got_pc.size()), 64'(n));
  endtask

  task automatic pulse_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n0;
    int cnt;
    int bad;
    reset = 1'b1;
    entry = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    insn_ready = 1'b1;
    tick(2);

    // T1: aligned entry, full burst delivered in order, next AR follows on
    insn_ready = 1'b1;
    do_reset(64'h1000);
    tick(1);
    check_eq("t1_arvalid_after_reset", m_axi_arvalid, 1);
    wait_insns(16, "t1_timeout");
    check_eq("t1_araddr", ar_log[0], 64'h1000);
    check_eq("t1_arlen", seen_arlen, 7);
    check_eq("t1_arsize", seen_arsize, 3);
    check_eq("t1_arburst", seen_arburst, 1);
    check_eq("t1_arcache", seen_arcache, 4'b0011);
    check_eq("t1_arprot", seen_arprot, 3'b100);
    check_eq("t1_arid", seen_arid, 0);
    check_eq("t1_arlock", seen_arlock, 0);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("t1_pc%0d", i), got_pc[i], 64'h1000 + 64'(4 * i));
      check_eq($sformatf("t1_data%0d", i), got_data[i], insn_of(64'h1000 + 64'(4 * i)));
    end
    cnt = 0;
    while (ar_log.size() < 2 && cnt < 100) begin tick(1); cnt++; end
    check_eq("t1_second_araddr", ar_log[1], 64'h1040);

    // T2: mid-burst entry skips earlier words
    do_reset(64'h100C);
    wait_insns(3, "t2_timeout");
    check_eq("t2_araddr", ar_log[0], 64'h1000);
    check_eq("t2_first_pc", got_pc[0], 64'h100C);
    check_eq("t2_first_data", got_data[0], insn_of(64'h100C));
    check_eq("t2_second_pc", got_pc[1], 64'h1010);
    check_eq("t2_third_pc", got_pc[2], 64'h1014);

    // T3: consumer stalled, prefetch fills FIFO and stops
    insn_ready = 1'b0;
    do_reset(64'h1000);
    tick(80);
    check_eq("t3_ar_count", 64'(ar_log.size()), 2);
    check_eq("t3_arvalid_idle", m_axi_arvalid, 0);
    check_eq("t3_insn_valid", insn_valid, 1);
    check_eq("t3_hold_pc", insn_pc, 64'h1000);
    check_eq("t3_hold_data", insn_data, insn_of(64'h1000));
    tick(10);
    check_eq("t3_hold_data_later", insn_data, insn_of(64'h1000));
    insn_ready = 1'b1;
    wait_insns(40, "t3_timeout");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (got_pc[i] !== 64'h1000 + 64'(4 * i) || got_data[i] !== insn_of(64'h1000 + 64'(4 * i))) bad++;
    end
    check_eq("t3_resume_seq_errors", 64'(bad), 0);

    // T4: redirect during beat 3 of the second burst
    do_reset(64'h1000);
    cnt = 0;
    while (!(slave_beat == 3 && slave_burst_addr == 64'h1040) && cnt < 300) begin tick(1); cnt++; end
    check_eq("t4_found_beat3", 64'(cnt < 300), 1);
    pulse_redirect(64'h2000);
    n0 = got_pc.size();
    bad = 0;
    for (int i = 0; i < n0; i++) if (got_pc[i] >= 64'h1058) bad++;
    check_eq("t4_no_stale_before", 64'(bad), 0);
    wait_insns(n0 + 8, "t4_timeout");
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t4_pc%0d", i), got_pc[n0 + i], 64'h2000 + 64'(4 * i));
    end
    check_eq("t4_first_data", got_data[n0], insn_of(64'h2000));
    check_eq("t4_redirect_araddr", ar_log[2], 64'h2000);

    // T5: redirect while AR is stalled by the slave
    ar_delay = 5;
    do_reset(64'h1000);
    cnt = 0;
    while (!m_axi_arvalid && cnt < 20) begin tick(1); cnt++; end
    check_eq("t5_arvalid_seen", m_axi_arvalid, 1);
    pulse_redirect(64'h3000);
    ar_delay = 0;
    wait_insns(2, "t5_timeout");
    check_eq("t5_first_araddr", ar_log[0], 64'h1000);
    check_eq("t5_ar_stable", 64'(ar_unstable), 0);
    check_eq("t5_second_araddr", ar_log[1], 64'h3000);
    check_eq("t5_first_pc", got_pc[0], 64'h3000);
    check_eq("t5_second_pc", got_pc[1], 64'h3004);

    // T6: error response on beat 2 stops fetching until redirect
    err_beat = 2;
    do_reset(64'h1000);
    tick(40);
    check_eq("t6_fetch_error", fetch_error, 1);
    check_eq("t6_delivered", 64'(got_pc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t6_pc%0d", i), got_pc[i], 64'h1000 + 64'(4 * i));
    end
    check_eq("t6_ar_count", 64'(ar_log.size()), 1);
    check_eq("t6_arvalid", m_axi_arvalid, 0);
    err_beat = -1;
    pulse_redirect(64'h4000);
    check_eq("t6_error_cleared", fetch_error, 0);
    wait_insns(6, "t6_timeout");
    check_eq("t6_resume_pc", got_pc[4], 64'h4000);
    check_eq("t6_resume_araddr", ar_log[1], 64'h4000);

    check_eq("slave_rready_timeouts", 64'(slave_timeout), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_fetch_prefetch.md
Name: axi_fetch_prefetch

Overview:
- Parametrised instruction-fetch front end.
- Issues aligned AXI4 INCR read bursts, buffers returned beats in a prefetch FIFO, and delivers one instruction per cycle with its PC over a valid/ready interface.
- Supports redirect (flush plus refetch from a new PC) with correct draining of in-flight bursts, and sticky error reporting.
- Sits between the AXI master port and the decode stage.

Parameters:
- ADDR_WIDTH, 64, AXI and PC address width.
- DATA_WIDTH, 64, AXI data width; must be a multiple of INSN_WIDTH.
- ID_WIDTH, 13, AXI ID width.
- INSN_WIDTH, 32, instruction width.
- BURST_BEATS, 8, beats per burst; power of 2; BURST_BYTES = BURST_BEATS*DATA_WIDTH/8, at most 4096.
- FIFO_BEATS, 16, prefetch FIFO depth in beats; power of 2 and at least BURST_BEATS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- entry  in  ADDR_WIDTH  PC loaded at reset; 4-byte aligned
- redirect_valid  in  1  one-cycle request to flush and refetch
- redirect_pc  in  ADDR_WIDTH  new PC; 4-byte aligned
- insn_valid  out  1  insn_data/insn_pc valid
- insn_ready  in  1  consumer accepts
- insn_data  out  INSN_WIDTH  instruction
- insn_pc  out  ADDR_WIDTH  address of insn_data
- fetch_error  out  1  sticky; set on rresp != OKAY
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  per AXI4  read address channel
- m_axi_arready  in  1  AXI read address ready
- m_axi_rid/rdata/rresp/rlast/rvalid  in  per AXI4  read data channel
- m_axi_rready  out  1  AXI read data ready

Behaviour:
- Reset values: arvalid=0, rready=0, insn_valid=0, fetch_error=0, FIFO empty, state IDLE, fetch_pc=entry.
- Constant AR fields:
  - arid=0, arlen=BURST_BEATS-1, arsize=log2(DATA_WIDTH/8), arburst=01 (INCR).
  - arlock=0, arcache=0011, arprot=100 (instruction access).
- araddr = fetch_pc with the low log2(BURST_BYTES) bits cleared.
- States:
  - IDLE: go to REQ when FIFO free beats >= BURST_BEATS and fetch_error=0. The first request asserts arvalid 1 cycle after reset deasserts.
  - REQ: arvalid=1. araddr and all AR fields stay stable until arready. On arready, go to BURST; fetch_pc = araddr + BURST_BYTES.
  - BURST: rready=1, held unconditionally because space was reserved. Each rvalid beat is written to the FIFO with its beat address and a start-slot index. On rlast, go to IDLE.
  - DRAIN: rready=1. Beats are discarded. On rlast, go to IDLE.
- Start slot:
  - First beat of a burst: slot of fetch_pc within the beat. Slots below it are skipped, so a mid-burst PC is never delivered early.
  - Later beats: slot 0.
- Output side:
  - FIFO head beat plus a slot pointer select insn_data = bits [slot*INSN_WIDTH +: INSN_WIDTH].
  - insn_pc = beat address + 4*slot.
  - Each insn_valid&insn_ready handshake advances the slot. Consuming the last slot pops the beat.
- Latency: insn_valid rises the cycle after the R handshake of the first useful beat. Throughput is 1 instruction/cycle while the FIFO is non-empty. insn_data and insn_pc are held stable while valid and not ready.
- Zero-valued instructions are delivered normally; this block never ends simulation.
- Redirect (highest priority, same-cycle effect):
  - FIFO flushed and insn_valid drops next cycle; a simultaneous insn handshake is ignored.
  - fetch_pc = redirect_pc; fetch_error cleared.
  - In REQ, the AR stays asserted until arready, then goes to DRAIN.
  - In BURST, go to DRAIN; a beat in the same cycle is discarded.
  - In DRAIN, stay in DRAIN with the new PC.
  - In IDLE, normal operation resumes.
- Error: a beat with rresp != 00 is discarded and fetch_error=1. Remaining beats of that burst are drained. No new AR is issued until redirect. Already-buffered instructions still deliver.
- Full/empty:
  - AR is issued only with BURST_BEATS free, so the FIFO never overflows.
  - FIFO pointers use 1 extra wrap bit.
  - A pop and push in the same cycle are both honoured.
- Reset mid-burst: returns to the reset state immediately. The bench must keep the slave quiet afterwards.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, BURST, DRAIN}.
  - fetch_beat_t struct {data, addr, start_slot}.
  - AXI constants: BURST_INCR, RESP_OKAY, ARCACHE_DEF, ARPROT_INSN.
  - Derived localparam helpers for SLOTS_PER_BEAT and BURST_BYTES.
- Sub-module fetch_beat_fifo: parametrised synchronous FIFO of fetch_beat_t with push, pop, flush, free_count and empty.

Test Plan:
- Reset with entry=0x1000; slave returns 8 beats of incrementing data -> AR araddr=0x1000, arlen=7, arsize=3, arburst=01. 16 instructions are delivered with insn_pc 0x1000..0x103C in order, and a second AR goes to 0x1040.
- entry=0x100C -> araddr=0x1000. First insn_pc=0x100C with data from the upper half of beat 1. 0x1000..0x1008 are never delivered.
- insn_ready held 0 -> exactly FIFO_BEATS/BURST_BEATS=2 bursts are fetched, then arvalid stays 0. insn_data is stable, and releasing ready resumes fetch with no loss.
- redirect_pc=0x2000 during beat 3 of a burst -> beats 3..7 are consumed and dropped, and no instruction from them appears. Next AR araddr=0x2000 and the first insn_pc=0x2000.
- Redirect while arvalid=1 and arready is held 0 for 5 cycles -> araddr is unchanged until arready, that burst is drained, then an AR goes to the redirect address.
- rresp=10 on beat 2 -> fetch_error=1, beats 0-1 are delivered, no further AR. A redirect clears fetch_error and fetching resumes.
